// File: rtl/alu_pipe.sv
// Pipelined ALU: valid/ready request port, one registered result stage with full
// backpressure, and a WIDTH-cycle iterative shift-add multiplier.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_illegal
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_LOAD
    } state_t;

    state_t            state;
    logic [SH_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]  mcand;
    logic [TAG_W-1:0]  mul_tag;
    logic [WIDTH:0]    mul_sum;

    logic [WIDTH:0]    add_full;
    logic [WIDTH-1:0]  sub_res;
    logic [SH_W-1:0]   shamt;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry;
    logic              alu_ovf;
    logic              alu_illegal;

    logic out_free;
    logic accept;
    logic is_mul;
    logic load_alu;
    logic load_mul;

    assign out_free = !out_valid || out_ready;
    assign in_ready = !rst && (state == S_IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (in_op == OP_MUL);
    assign load_alu = accept && !is_mul;
    assign load_mul = (state == S_LOAD) && out_free;

    assign add_full = {1'b0, in_a} + {1'b0, in_b};
    assign sub_res  = in_a - in_b;
    assign shamt    = in_b[SH_W-1:0];

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (in_a[MSB] == in_b[MSB]) && (add_full[MSB] != in_a[MSB]);
            end
            OP_SUB: begin
                alu_res   = sub_res;
                alu_carry = (in_a < in_b);
                alu_ovf   = (in_a[MSB] != in_b[MSB]) && (sub_res[MSB] != in_a[MSB]);
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_SLL:  alu_res = in_a << shamt;
            OP_SRL:  alu_res = in_a >> shamt;
            OP_SRA:  alu_res = $signed(in_a) >>> shamt;
            OP_SLT:  alu_res = WIDTH'($signed(in_a) < $signed(in_b));
            OP_SLTU: alu_res = WIDTH'(in_a < in_b);
            OP_MUL:  alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand to the upper half, then shift right.
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

    // NOTE: the multiplier datapath is left without reset; it is only read in S_MUL/S_LOAD,
    // which are reached solely through an accept edge that loads it.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            prod    <= {{WIDTH{1'b0}}, in_b};
            mcand   <= in_a;
            mul_tag <= in_tag;
        end else if (state == S_MUL) begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_zero    <= 1'b0;
            out_neg     <= 1'b0;
            out_carry   <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (load_alu) begin
                out_valid   <= 1'b1;
                out_result  <= alu_res;
                out_tag     <= in_tag;
                out_zero    <= (alu_res == '0);
                out_neg     <= alu_res[MSB];
                out_carry   <= alu_carry;
                out_ovf     <= alu_ovf;
                out_illegal <= alu_illegal;
            end else if (load_mul) begin
                out_valid   <= 1'b1;
                out_result  <= prod[WIDTH-1:0];
                out_tag     <= mul_tag;
                out_zero    <= (prod[WIDTH-1:0] == '0);
                out_neg     <= prod[MSB];
                out_carry   <= |prod[2*WIDTH-1:WIDTH];
                out_ovf     <= 1'b0;
                out_illegal <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        state <= S_MUL;
                        cnt   <= '0;
                    end
                end
                S_MUL: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (out_free) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic checked
// against an arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe;

    localparam int W  = 32;
    localparam int TW = 4;

    typedef struct packed {
        logic [W-1:0]  result;
        logic [TW-1:0] tag;
        logic          zero;
        logic          neg;
        logic          carry;
        logic          ovf;
        logic          illegal;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          out_zero;
    logic          out_neg;
    logic          out_carry;
    logic          out_ovf;
    logic          out_illegal;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    res_t exp_q[$];
    res_t got_q[$];
    int   got_cyc[$];

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Records every delivery (handshake seen at the negedge completes on the next posedge).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back({out_result, out_tag, out_zero, out_neg, out_carry, out_ovf, out_illegal});
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(logic [W-1:0] r, logic [TW-1:0] t,
                                logic z, logic n, logic c, logic v, logic il);
        mk = {r, t, z, n, c, v, il};
    endfunction

    // Reference model: wide integer arithmetic, flags derived from the mathematical result.
    function automatic res_t model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [TW-1:0] tag);
        res_t        r;
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] u;
        logic [4:0]  sh;
        r  = '0;
        r.tag = tag;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b[4:0];
        case (op)
            4'd0: begin
                u = 64'(a) + 64'(b);
                r.result = u[31:0];
                r.carry  = u[32];
                s = sa + sb;
                r.ovf = (s != longint'($signed(r.result)));
            end
            4'd1: begin
                u = 64'(a) - 64'(b);
                r.result = u[31:0];
                r.carry  = (a < b);
                s = sa - sb;
                r.ovf = (s != longint'($signed(r.result)));
            end
            4'd2: r.result = a & b;
            4'd3: r.result = a | b;
            4'd4: r.result = a ^ b;
            4'd5: r.result = a << sh;
            4'd6: r.result = a >> sh;
            4'd7: begin
                s = sa >>> sh;
                r.result = s[31:0];
            end
            4'd8: r.result = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r.result = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                u = 64'(a) * 64'(b);
                r.result = u[31:0];
                r.carry  = (u[63:32] != 32'd0);
            end
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.result == 32'd0);
        r.neg  = r.result[31];
        return r;
    endfunction

    // Presents one request and holds it until accepted; expected result goes on exp_q.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout op=%0d tag=%0d: in_ready=%b after %0d cycles, want 1", op, tag, in_ready, waited);
        end else begin
            exp_q.push_back(model(op, a, b, tag));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int waited;
        waited = 0;
        while (got_q.size() < n && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results, want %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_result, out_tag, out_zero, out_neg, out_carry, out_ovf, out_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b result=%h tag=%h flags=%b%b%b%b%b want all 0",
                     out_valid, out_result, out_tag, out_zero, out_neg, out_carry, out_ovf, out_illegal);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_add_flags();
        res_t got;
        out_ready = 1'b1;
        exp_q.delete();
        got_q.delete();
        issue(4'd0, 32'hFFFF_FFFF, 32'h1, 4'd3);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h0 || out_tag !== 4'd3) begin
            errors++;
            $display("FAIL add_latency: valid=%b result=%h tag=%h want 1/00000000/3", out_valid, out_result, out_tag);
        end
        issue(4'd0, 32'h7FFF_FFFF, 32'h1, 4'd5);
        drain(2);
        if (got_q.size() >= 2) begin
            got = got_q.pop_front();
            checks++;
            if (got !== mk(32'h0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL add_carry: got %h want %h", got, mk(32'h0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            end
            got = got_q.pop_front();
            checks++;
            if (got !== mk(32'h8000_0000, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL add_ovf: got %h want %h", got, mk(32'h8000_0000, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_sub_cmp_shift();
        res_t want[4];
        res_t got;
        exp_q.delete();
        got_q.delete();
        want[0] = mk(32'hFFFF_FFFE, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        want[1] = mk(32'h1,         4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        want[2] = mk(32'h0,         4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want[3] = mk(32'hF800_0000, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(4'd1, 32'd5, 32'd7, 4'd1);
        issue(4'd8, 32'hFFFF_FFFF, 32'h1, 4'd2);
        issue(4'd9, 32'hFFFF_FFFF, 32'h1, 4'd3);
        issue(4'd7, 32'h8000_0000, 32'h24, 4'd4);
        drain(4);
        for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
            got = got_q.pop_front();
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("FAIL sub_cmp_shift[%0d]: got %h want %h", i, got, want[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int   start;
        res_t got;
        res_t exp;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        start = cyc;
        for (int i = 0; i < 8; i++) begin
            issue(4'($urandom_range(0, 9)), $urandom, $urandom, 4'(i));
        end
        checks++;
        if (cyc - start != 8) begin
            errors++;
            $display("FAIL b2b_throughput: 8 ops took %0d cycles, want 8", cyc - start);
        end
        drain(8);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            got = got_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_result: got %h want %h", got, exp);
            end
        end
    endtask

    task automatic test_mul_timing();
        int   bad;
        res_t got;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        bad = 0;
        issue(4'd10, 32'h0001_0000, 32'h0001_0000, 4'd7);
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mul_busy: %0d of 33 cycles had in_ready or out_valid set, want 0", bad);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_latency: after edge N+33 valid=%b in_ready=%b want 1/1", out_valid, in_ready);
        end
        drain(1);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            checks++;
            if (got !== mk(32'h0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL mul_result: got %h want %h", got, mk(32'h0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        res_t got;
        res_t exp;
        res_t first;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        int bad;
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        out_ready = 1'b0;
        issue(4'd0, $urandom, $urandom, 4'd1);
        first = exp_q[0];
        a2 = $urandom;
        b2 = $urandom;
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_a     = a2;
        in_b     = b2;
        in_tag   = 4'd2;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== first.result || out_tag !== 4'd1) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d of 4 stalled cycles wrong (ready/valid/result/tag), want 0", bad);
        end
        out_ready = 1'b1;
        issue(4'd0, a2, b2, 4'd2);
        issue(4'd0, $urandom, $urandom, 4'd3);
        drain(3);
        checks++;
        if (got_cyc.size() < 3 || got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
            errors++;
            $display("FAIL bp_consecutive: %0d deliveries, not on consecutive cycles", got_cyc.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            got = got_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bp_result: got %h want %h", got, exp);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL bp_duplicate: %0d extra deliveries, want 0", got_q.size());
        end
    endtask

    task automatic test_mul_stall();
        res_t exp;
        res_t got;
        int   bad;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b0;
        issue(4'd10, $urandom, $urandom, 4'd9);
        exp = exp_q.pop_front();
        repeat (33) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_stall_load: valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {out_result, out_tag, out_zero, out_neg, out_carry, out_ovf, out_illegal} !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mul_stall_hold: %0d of 3 stalled cycles wrong, want 0", bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_stall_ready: in_ready=%b want 1 once out_ready rises", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_stall_release: valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        drain(1);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mul_stall_result: got %h want %h", got, exp);
            end
        end
    endtask

    task automatic test_illegal();
        res_t got;
        res_t exp;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        issue(4'd13, $urandom, $urandom, 4'd4);
        for (int op = 11; op <= 15; op++) issue(4'(op), $urandom, $urandom, 4'(op));
        drain(6);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            void'(exp_q.pop_front());
            checks++;
            if (got !== mk(32'h0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)) begin
                errors++;
                $display("FAIL illegal13: got %h want %h", got, mk(32'h0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            got = got_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL illegal_sweep: got %h want %h", got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        issue(4'd10, $urandom, $urandom, 4'd11);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mul_ready_low: in_ready=%b want 0 during reset", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mul_idle: in_ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mul_abort: valid high %0d cycles, %0d deliveries, want 0/0", bad, got_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        localparam int N = 150;
        bit   done;
        int   unstable;
        res_t got;
        res_t exp;
        exp_q.delete();
        got_q.delete();
        done     = 1'b0;
        unstable = 0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    int r;
                    logic [3:0] op;
                    r = $urandom_range(0, 99);
                    if (r < 8)       op = 4'd10;
                    else if (r < 12) op = 4'($urandom_range(11, 15));
                    else             op = 4'($urandom_range(0, 9));
                    issue(op, $urandom, $urandom, 4'($urandom));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                logic         held;
                logic [W+TW+4:0] prev;
                held = 1'b0;
                prev = '0;
                while (!done) begin
                    @(negedge clk);
                    if (held && (out_valid !== 1'b1 ||
                        {out_result, out_tag, out_zero, out_neg, out_carry, out_ovf, out_illegal} !== prev))
                        unstable++;
                    held = out_valid && !out_ready;
                    prev = {out_result, out_tag, out_zero, out_neg, out_carry, out_ovf, out_illegal};
                end
            end
        join
        out_ready = 1'b1;
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL rand_stability: outputs changed on %0d stalled cycles, want 0", unstable);
        end
        drain(N);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d results, want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            got = got_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_result: got %h want %h", got, exp);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_add_flags();
        test_sub_cmp_shift();
        test_back_to_back();
        test_mul_timing();
        test_backpressure();
        test_mul_stall();
        test_illegal();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, handshaked successor to the combinational datapath ALU: a WIDTH-generic arithmetic/logic unit with a valid/ready operand interface, a registered result stage with full backpressure, an extended op set (arithmetic shift, signed/unsigned compare) and a multi-cycle iterative multiplier. It sits between the operand-issue logic and the writeback stage. Each accepted request returns exactly one result, in request order, with a caller tag and four status flags.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two
- TAG_W, 4, width of the opaque request tag returned with the result
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted on an edge where in_valid && in_ready
- in_op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL; 11–15 illegal
- in_a, in_b  in  WIDTH  operands
- in_tag  in  TAG_W  returned unchanged with the result
- out_valid  out  1  result register holds an undelivered result
- out_ready  in  1  consumer accepts the result on an edge where out_valid && out_ready
- out_result  out  WIDTH  result
- out_tag  out  TAG_W  tag of the request that produced out_result
- out_zero, out_neg, out_carry, out_ovf  out  1 each  status flags
- out_illegal  out  1  result came from an illegal op

## Operation
- Shift amount: in_b[$clog2(WIDTH)-1:0]. The upper bits of in_b are ignored.
- SRA replicates in_a[WIDTH-1]. SLL and SRL shift in zeros.
- SLT: signed compare. SLTU: unsigned compare. Both return 1 if a < b, else 0, zero-extended to WIDTH.
- MUL returns the low WIDTH bits of the unsigned 2·WIDTH-bit product.
- Illegal op: result 0, out_illegal = 1, all other flags follow the flag rules applied to result 0.
- Flags:
  - zero = (result == 0).
  - neg = result[WIDTH-1].
  - carry:
    - ADD: carry-out.
    - SUB: borrow, i.e. a < b unsigned.
    - MUL: 1 if the high product half ≠ 0.
    - All other ops: 0.
  - ovf: signed overflow for ADD/SUB; 0 for all other ops.
- FSM states:
  - IDLE: accepts any op. A single-cycle op is computed combinationally and loaded into the result register on the acceptance edge. MUL latches the operands and tag, then goes to MUL.
  - MUL: one shift-add iteration per cycle for WIDTH cycles, driven by an internal counter. After the final iteration, the next edge goes to LOAD.
  - LOAD: if the result register is free (!out_valid || out_ready), load the product and flags and go to IDLE. Otherwise hold in LOAD.
- in_ready = !rst && state == IDLE && (!out_valid || out_ready). This is combinational and has no dependency on in_valid.
- The result register loads only when free. A delivery and a new load on the same edge leaves out_valid = 1 with the new contents.
- out_* data and flags are stable while out_valid && !out_ready.

## Timing
- Reset, and values on the first edge with rst = 1:
  - state = IDLE, out_valid = 0, out_result = 0, out_tag = 0, all flags 0, out_illegal = 0, MUL counter = 0.
  - in_ready = 0 while rst = 1.
- Reset mid-MUL aborts the multiply. No result is ever delivered for it.
- Single-cycle op accepted at edge N: out_valid = 1 after edge N.
- Throughput is one op per cycle while out_ready = 1.
- MUL accepted at edge N:
  - Iterations occur on edges N+1 … N+WIDTH.
  - Edge N+WIDTH+1 is the LOAD attempt.
  - out_valid = 1 after edge N+WIDTH+1 if the result register is free; otherwise it loads on the first edge where the register is free.
- in_ready = 0 from acceptance of a MUL until the edge on which LOAD completes. A new request can be accepted on the cycle after LOAD.
- Ordering is strict. No request overtakes a pending MUL.

## Test plan
- Reset, then WIDTH=32, out_ready=1. Send ADD 0xFFFFFFFF+1, tag 3 -> one cycle later: result 0, zero=1, carry=1, ovf=0, tag 3. Send ADD 0x7FFFFFFF+1 -> result 0x80000000, neg=1, ovf=1, carry=0.
- SUB 5−7, then SLT 0xFFFFFFFF vs 1, then SLTU 0xFFFFFFFF vs 1, then SRA 0x80000000 by b=0x24 (uses amount 4) -> results, in order:
  - SUB: 0xFFFFFFFE, carry=1, neg=1.
  - SLT: 1.
  - SLTU: 0.
  - SRA: 0xF8000000.
- MUL 0x10000 × 0x10000, accepted at edge N -> in_ready=0 for edges N..N+32; result 0, carry=1, zero=1, out_valid after edge N+33.
- Backpressure: send 3 ADDs back-to-back with out_ready=0 -> only the first is accepted and out_result is held. Then raise out_ready -> the remaining two arrive on consecutive cycles, with no loss or duplication.
- MUL completes while out_ready=0 -> FSM holds in LOAD, in_ready=0. Raise out_ready -> the pending result is delivered, then the product loads on the same edge; in_ready=1 on the next cycle.
- Illegal op 13 -> result 0, out_illegal=1, zero=1. Assert rst at iteration 10 of a MUL -> out_valid stays 0, state returns to IDLE, in_ready=1 after rst is released.
